// File: rtl/camera_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : camera_frame_source
// Description : Synthetic camera front end. Generates a deterministic RGB
//               test frame (R = column, G = line, B = frame count), packed
//               N_POINTS pixels per bus word, one word per request /
//               acknowledge / send handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module camera_frame_source #(
  parameter int BUS_WIDTH    = 96,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 recieve_ready,
  output logic                 in_progress,
  output logic [BUS_WIDTH-1:0] data,
  output logic                 data_valid,
  output logic                 frame_end
);

  localparam int c_n_points = BUS_WIDTH / 24;
  localparam int c_xw       = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int c_yw       = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [c_xw-1:0] c_x_last = c_xw'(FRAME_WIDTH - c_n_points);
  localparam logic [c_yw-1:0] c_y_last = c_yw'(FRAME_HEIGHT - 1);
  localparam logic [c_xw-1:0] c_x_step = c_xw'(c_n_points);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_xw-1:0] r_x;
  logic [c_yw-1:0] r_y;
  logic [7:0]      r_frame_cnt;

  logic                 w_last_x;
  logic                 w_last_y;
  logic [BUS_WIDTH-1:0] w_beat;

  assign w_last_x = (r_x == c_x_last);
  assign w_last_y = (r_y == c_y_last);

  // Pixel k of the current beat: column, line and frame number, each truncated to 8 bits
  for (genvar k = 0; k < c_n_points; k++) begin : g_points
    assign w_beat[24*k +: 24] = {8'(32'(r_x) + k), 8'(r_y), r_frame_cnt};
  end

  // Handshake FSM with registered outputs; position counters advance on leaving SEND
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
      in_progress <= 1'b0;
      data        <= '0;
      data_valid  <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          data_valid <= 1'b0;
          frame_end  <= 1'b0;
          if (recieve_ready) begin
            r_state     <= S_ARMED;
            in_progress <= 1'b1;
          end
        end
        S_ARMED: begin
          // The consumer acknowledges by dropping its request
          if (!recieve_ready) begin
            r_state    <= S_SEND;
            data_valid <= 1'b1;
            data       <= w_beat;
            frame_end  <= w_last_x && w_last_y;
          end
        end
        S_SEND: begin
          r_state     <= S_IDLE;
          data_valid  <= 1'b0;
          frame_end   <= 1'b0;
          in_progress <= 1'b0;
          if (w_last_x) begin
            r_x <= '0;
            if (w_last_y) begin
              r_y         <= '0;
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end else begin
              r_y <= r_y + c_yw'(1);
            end
          end else begin
            r_x <= r_x + c_x_step;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          in_progress <= 1'b0;
          data_valid  <= 1'b0;
          frame_end   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_camera_frame_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_camera_frame_source
// Description : Self-checking bench for camera_frame_source with a small
//               frame (8x2) and a frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_frame_source;

  localparam int BW = 96;
  localparam int FW = 8;
  localparam int FH = 2;
  localparam int NP = BW / 24;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b0;
  logic          recieve_ready = 1'b0;
  logic          in_progress;
  logic [BW-1:0] data;
  logic          data_valid;
  logic          frame_end;

  int errors = 0;
  int checks = 0;

  // Reference model position
  int m_x = 0;
  int m_y = 0;
  int m_f = 0;

  camera_frame_source #(
    .BUS_WIDTH   (BW),
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .recieve_ready(recieve_ready),
    .in_progress  (in_progress),
    .data         (data),
    .data_valid   (data_valid),
    .frame_end    (frame_end)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] model_data(input int x, input int y, input int f);
    logic [BW-1:0] d;
    d = '0;
    for (int k = 0; k < NP; k++) begin
      d[24*k +: 24] = {8'((x + k) % 256), 8'(y % 256), 8'(f % 256)};
    end
    return d;
  endfunction

  function automatic logic model_fe(input int x, input int y);
    return (x + NP == FW) && (y == FH - 1);
  endfunction

  function automatic void model_advance();
    if (m_x + NP == FW) begin
      m_x = 0;
      if (m_y == FH - 1) begin
        m_y = 0;
        m_f = (m_f + 1) % 256;
      end else begin
        m_y = m_y + 1;
      end
    end else begin
      m_x = m_x + NP;
    end
  endfunction

  function automatic void model_reset();
    m_x = 0;
    m_y = 0;
    m_f = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Performs one handshake and captures what the DUT showed; compares nothing
  task automatic run_beat(input int hold, output logic ip_req, output logic dv_early,
                          output logic held_bad, output logic [BW-1:0] d,
                          output logic dv, output logic fe, output logic ip_send,
                          output logic dv_after, output logic fe_after,
                          output logic ip_after);
    recieve_ready = 1'b1;
    step();
    ip_req   = in_progress;
    dv_early = data_valid;
    held_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (data_valid !== 1'b0 || in_progress !== 1'b1) held_bad = 1'b1;
    end
    recieve_ready = 1'b0;
    step();
    dv      = data_valid;
    d       = data;
    fe      = frame_end;
    ip_send = in_progress;
    step();
    dv_after = data_valid;
    fe_after = frame_end;
    ip_after = in_progress;
  endtask

  task automatic test_reset();
    sys_rst = 1'b0;
    recieve_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({in_progress, data_valid, frame_end, data} !== '0) begin
        errors++;
        $display("FAIL reset_hold: got ip=%b dv=%b fe=%b data=%h, want all 0",
                 in_progress, data_valid, frame_end, data);
      end
    end
    sys_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({in_progress, data_valid, frame_end, data} !== '0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d got ip=%b dv=%b fe=%b data=%h, want all 0",
                 i, in_progress, data_valid, frame_end, data);
      end
    end
    model_reset();
  endtask

  // One beat with full timing and content checks against the model
  task automatic test_beat(input string name, input int hold);
    logic ip_req, dv_early, held_bad, dv, fe, ip_send, dv_after, fe_after, ip_after;
    logic [BW-1:0] d, exp_d;
    logic exp_fe;
    exp_d  = model_data(m_x, m_y, m_f);
    exp_fe = model_fe(m_x, m_y);
    run_beat(hold, ip_req, dv_early, held_bad, d, dv, fe, ip_send, dv_after, fe_after, ip_after);
    checks++;
    if (ip_req !== 1'b1 || dv_early !== 1'b0 || held_bad !== 1'b0) begin
      errors++;
      $display("FAIL %s_armed: ip=%b dv=%b held_bad=%b, want ip=1 dv=0 held_bad=0",
               name, ip_req, dv_early, held_bad);
    end
    checks++;
    if (dv !== 1'b1 || ip_send !== 1'b1) begin
      errors++;
      $display("FAIL %s_strobe: dv=%b ip=%b, want dv=1 ip=1", name, dv, ip_send);
    end
    checks++;
    if (d !== exp_d) begin
      errors++;
      $display("FAIL %s_data: got %h, want %h", name, d, exp_d);
    end
    checks++;
    if (fe !== exp_fe) begin
      errors++;
      $display("FAIL %s_frame_end: got %b, want %b", name, fe, exp_fe);
    end
    checks++;
    if (dv_after !== 1'b0 || fe_after !== 1'b0 || ip_after !== 1'b0 || data !== exp_d) begin
      errors++;
      $display("FAIL %s_after: dv=%b fe=%b ip=%b data=%h, want 0 0 0 data=%h",
               name, dv_after, fe_after, ip_after, data, exp_d);
    end
    model_advance();
  endtask

  task automatic test_first_beat();
    checks++;
    if (model_data(m_x, m_y, m_f) !== {24'h030000, 24'h020000, 24'h010000, 24'h000000}) begin
      errors++;
      $display("FAIL first_model: model position x=%0d y=%0d f=%0d, want origin", m_x, m_y, m_f);
    end
    test_beat("first", 0);
  endtask

  task automatic test_full_frame();
    test_beat("beat2", 0);
    test_beat("beat3", 1);
    test_beat("beat4", 0);
  endtask

  task automatic test_frame_wrap();
    test_beat("wrap", 0);
  endtask

  task automatic test_held_request();
    test_beat("held", 49);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) step();
      test_beat("rand", int'($urandom_range(0, 4)));
    end
  endtask

  task automatic test_reset_mid();
    sys_rst = 1'b0;
    step();
    sys_rst = 1'b1;
    step();
    model_reset();
    test_beat("mid_pre1", 0);
    test_beat("mid_pre2", 0);
    recieve_ready = 1'b1;
    step();
    step();
    checks++;
    if (in_progress !== 1'b1) begin
      errors++;
      $display("FAIL mid_armed: ip=%b, want 1", in_progress);
    end
    #2;
    sys_rst = 1'b0;
    #1;
    checks++;
    if (in_progress !== 1'b0 || data !== '0 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: ip=%b dv=%b data=%h, want all 0", in_progress, data_valid, data);
    end
    recieve_ready = 1'b0;
    step();
    step();
    sys_rst = 1'b1;
    step();
    model_reset();
    test_beat("mid_post", 0);
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_full_frame();
    test_frame_wrap();
    test_held_request();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
